// File: rtl/cpu_control_fsm_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
   } state_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
      ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
      ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4
   } imm_sel_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0, WB_RAM = 2'd1, WB_PC4 = 2'd2
   } wb_sel_e;

   // CL_ALU covers everything that retires through WB with an ALU result.
   typedef enum logic [2:0] {
      CL_ALU, CL_JUMP, CL_LOAD, CL_STORE, CL_BRANCH, CL_FENCE, CL_SYSTEM, CL_ILLEGAL
   } instr_class_e;

   function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
      case (f3)
         3'b000:         return eq;
         3'b001:         return !eq;
         3'b100, 3'b110: return lt;
         3'b101, 3'b111: return !lt;
         default:        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control bus between the sequencer (master) and the RAM/register-file/ALU datapath (slave).
interface cpu_control_fsm_if #(parameter int CC_WIDTH = 4);
   logic [31:0]         instr;
   logic                memReady;
   logic                BrEq;
   logic                BrLT;
   logic [31:0]         irOut;
   logic                pcEn;
   logic                PCSel;
   logic [2:0]          ImmSel;
   logic                RegWEn;
   logic                ASel;
   logic                BSel;
   logic                BrUn;
   logic [1:0]          WBSel;
   logic [3:0]          ALUop;
   logic                ramEn;
   logic                MemRW;
   logic [CC_WIDTH-1:0] cycleCount;
   logic                halted;

   modport master (
      input  instr, memReady, BrEq, BrLT,
      output irOut, pcEn, PCSel, ImmSel, RegWEn, ASel, BSel, BrUn, WBSel, ALUop,
             ramEn, MemRW, cycleCount, halted
   );

   modport slave (
      output instr, memReady, BrEq, BrLT,
      input  irOut, pcEn, PCSel, ImmSel, RegWEn, ASel, BSel, BrUn, WBSel, ALUop,
             ramEn, MemRW, cycleCount, halted
   );
endinterface

// File: rtl/cpu_control_fsm_decode.sv
// Combinational instruction decode: latched instruction fields to datapath selects and class.
module cpu_instr_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [6:0]   opcode,
   input  logic [2:0]   funct3,
   input  logic [6:0]   funct7,
   input  logic [4:0]   rd,
   output instr_class_e cls,
   output logic         legal,
   output logic [2:0]   imm_sel,
   output logic         a_sel,
   output logic         b_sel,
   output logic         br_un,
   output logic [1:0]   wb_sel,
   output logic [3:0]   alu_op,
   output logic         rd_nz
);

   assign rd_nz = |rd;
   assign legal = (cls != CL_ILLEGAL);

   always_comb begin
      cls     = CL_ILLEGAL;
      imm_sel = IMM_I;
      a_sel   = 1'b0;
      b_sel   = 1'b1;
      br_un   = 1'b0;
      wb_sel  = WB_ALU;
      alu_op  = ALU_ADD;
      case (opcode)
         OPC_OP: begin
            b_sel  = 1'b0;
            alu_op = alu_decode(funct3, funct7[5]);
            if (funct7 == F7_BASE || (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))
               cls = CL_ALU;
         end
         OPC_OP_IMM: begin
            alu_op = alu_decode(funct3, funct3 == 3'b101 && funct7[5]);
            // Only the shift-immediates use the upper bits as an encoding field.
            if ((funct3 != 3'b001 && funct3 != 3'b101) || funct7 == F7_BASE ||
                (funct3 == 3'b101 && funct7 == F7_ALT))
               cls = CL_ALU;
         end
         OPC_LUI: begin
            cls     = CL_ALU;
            imm_sel = IMM_U;
            alu_op  = ALU_PASSB;
         end
         OPC_AUIPC: begin
            cls     = CL_ALU;
            imm_sel = IMM_U;
            a_sel   = 1'b1;
         end
         OPC_JAL: begin
            cls     = CL_JUMP;
            imm_sel = IMM_J;
            a_sel   = 1'b1;
            wb_sel  = WB_PC4;
         end
         OPC_JALR: begin
            if (funct3 == 3'b000) cls = CL_JUMP;
            wb_sel = WB_PC4;
         end
         OPC_LOAD: begin
            if (funct3 == 3'b010) cls = CL_LOAD;
            wb_sel = WB_RAM;
         end
         OPC_STORE: begin
            if (funct3 == 3'b010) cls = CL_STORE;
            imm_sel = IMM_S;
         end
         OPC_BRANCH: begin
            if (funct3[2:1] != 2'b01) cls = CL_BRANCH;
            imm_sel = IMM_B;
            a_sel   = 1'b1;
            br_un   = funct3[1];
         end
         OPC_FENCE:  cls = CL_FENCE;
         OPC_SYSTEM: cls = CL_SYSTEM;
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32I datapath controls.
module cpu_control_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int CC_WIDTH        = 4,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input logic            clk,
   input logic            rst,
   cpu_control_fsm_if.master bus
);

   state_e              state_q, state_d;
   logic [31:0]         ir_q, ir_d;
   logic [CC_WIDTH-1:0] cc_q, cc_d;

   instr_class_e cls;
   logic         legal, dec_a_sel, dec_b_sel, dec_br_un, rd_nz;
   logic [2:0]   dec_imm_sel;
   logic [1:0]   dec_wb_sel;
   logic [3:0]   dec_alu_op;

   logic       pc_en, pc_sel, reg_wen, ram_en, mem_rw, a_sel, halted, use_dec;

   cpu_instr_decode u_decode (
      .opcode  (ir_q[6:0]),
      .funct3  (ir_q[14:12]),
      .funct7  (ir_q[31:25]),
      .rd      (ir_q[11:7]),
      .cls     (cls),
      .legal   (legal),
      .imm_sel (dec_imm_sel),
      .a_sel   (dec_a_sel),
      .b_sel   (dec_b_sel),
      .br_un   (dec_br_un),
      .wb_sel  (dec_wb_sel),
      .alu_op  (dec_alu_op),
      .rd_nz   (rd_nz)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FETCH;
         ir_q    <= '0;
         cc_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cc_q    <= cc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      pc_en   = 1'b0;
      pc_sel  = 1'b0;
      reg_wen = 1'b0;
      ram_en  = 1'b0;
      mem_rw  = 1'b0;
      a_sel   = 1'b0;
      halted  = 1'b0;
      use_dec = 1'b0;
      case (state_q)
         ST_FETCH: begin
            ram_en = 1'b1;
            a_sel  = 1'b1;
            if (bus.memReady) begin
               ir_d    = bus.instr;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            use_dec = 1'b1;
            if (cls == CL_SYSTEM || (!legal && TRAP_ON_ILLEGAL)) state_d = ST_TRAP;
            else                                                state_d = ST_EXEC;
         end
         ST_EXEC: begin
            use_dec = 1'b1;
            case (cls)
               CL_BRANCH: begin
                  pc_en   = 1'b1;
                  pc_sel  = branch_taken(ir_q[14:12], bus.BrEq, bus.BrLT);
                  state_d = ST_FETCH;
               end
               CL_FENCE, CL_ILLEGAL: begin
                  pc_en   = 1'b1;
                  state_d = ST_FETCH;
               end
               CL_LOAD, CL_STORE: state_d = ST_MEM;
               default:           state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            use_dec = 1'b1;
            ram_en  = 1'b1;
            mem_rw  = (cls == CL_STORE);
            if (bus.memReady) begin
               pc_en   = (cls == CL_STORE);
               state_d = (cls == CL_STORE) ? ST_FETCH : ST_WB;
            end
         end
         ST_WB: begin
            use_dec = 1'b1;
            reg_wen = rd_nz;
            pc_en   = 1'b1;
            pc_sel  = (cls == CL_JUMP);
            state_d = ST_FETCH;
         end
         ST_TRAP:  halted  = 1'b1;
         default:  state_d = ST_FETCH;
      endcase
      if (use_dec) a_sel = dec_a_sel;

      cc_d = cc_q;
      if (state_d == ST_FETCH && state_q != ST_FETCH) cc_d = '0;
      else if (cc_q != {CC_WIDTH{1'b1}})              cc_d = cc_q + 1'b1;
   end

   // Reset overrides every output combinationally so nothing leaks while rst is high.
   assign bus.irOut      = ir_q;
   assign bus.cycleCount = cc_q;
   assign bus.pcEn       = pc_en & ~rst;
   assign bus.PCSel      = pc_sel & ~rst;
   assign bus.RegWEn     = reg_wen & ~rst;
   assign bus.ramEn      = ram_en & ~rst;
   assign bus.MemRW      = mem_rw & ~rst;
   assign bus.ASel       = a_sel & ~rst;
   assign bus.halted     = halted & ~rst;
   assign bus.BSel       = dec_b_sel & use_dec & ~rst;
   assign bus.BrUn       = dec_br_un & use_dec & ~rst;
   assign bus.ImmSel     = (use_dec && !rst) ? dec_imm_sel : 3'd0;
   assign bus.WBSel      = (use_dec && !rst) ? dec_wb_sel : 2'd0;
   assign bus.ALUop      = (use_dec && !rst) ? dec_alu_op : 4'd0;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: directed scenarios plus random instructions against a timeline model.
module tb_cpu_control_fsm;
   localparam int CCW = 4;
   localparam int K_OP = 0, K_OPIMM = 1, K_LUI = 2, K_AUIPC = 3, K_JAL = 4,
                  K_JALR = 5, K_LOAD = 6, K_STORE = 7, K_BRANCH = 8, K_FENCE = 9;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   cpu_control_fsm_if #(.CC_WIDTH(CCW)) bus ();

   cpu_control_fsm #(.CC_WIDTH(CCW), .TRAP_ON_ILLEGAL(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ":pcEn"},   32'(bus.pcEn), 0);
      chk({tag, ":RegWEn"}, 32'(bus.RegWEn), 0);
      chk({tag, ":ramEn"},  32'(bus.ramEn), 0);
      chk({tag, ":MemRW"},  32'(bus.MemRW), 0);
      chk({tag, ":PCSel"},  32'(bus.PCSel), 0);
      chk({tag, ":ASel"},   32'(bus.ASel), 0);
      chk({tag, ":BSel"},   32'(bus.BSel), 0);
      chk({tag, ":BrUn"},   32'(bus.BrUn), 0);
      chk({tag, ":ImmSel"}, 32'(bus.ImmSel), 0);
      chk({tag, ":WBSel"},  32'(bus.WBSel), 0);
      chk({tag, ":ALUop"},  32'(bus.ALUop), 0);
      chk({tag, ":halted"}, 32'(bus.halted), 0);
      chk({tag, ":irOut"},  bus.irOut, 0);
      chk({tag, ":cc"},     32'(bus.cycleCount), 0);
   endtask

   function automatic int alu_ref(input logic [2:0] f3, input logic alt);
      int tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      if (f3 == 3'b000 && alt) return 1;
      if (f3 == 3'b101 && alt) return 7;
      return tab[f3];
   endfunction

   // Entered aligned to a falling edge; leaves 1 time unit after the next one.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      bus.memReady = 1'b0;
      #1;
      chk_all_zero({tag, ":held"});
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk({tag, ":cc"},     32'(bus.cycleCount), 0);
      chk({tag, ":irOut"},  bus.irOut, 0);
      chk({tag, ":ramEn"},  32'(bus.ramEn), 1);
      chk({tag, ":halted"}, 32'(bus.halted), 0);
      chk({tag, ":pcEn"},   32'(bus.pcEn), 0);
   endtask

   // Timeline model: fetch (fw waits), decode, exec, optional mem (mw waits), optional wb.
   task automatic run_instr(input logic [31:0] ins, input int k, input int fw, input int mw,
                            input logic eq, input logic lt);
      logic [2:0] f3;
      bit has_mem, has_wb, jump, writes, taken, in_fetch, in_mem, last;
      int total, mem_start, e_alu, e_imm, e_asel, e_bsel;
      f3      = ins[14:12];
      has_mem = (k == K_LOAD || k == K_STORE);
      has_wb  = !(k == K_STORE || k == K_BRANCH || k == K_FENCE);
      jump    = (k == K_JAL || k == K_JALR);
      writes  = has_wb && (ins[11:7] != 5'd0);
      case (f3)
         3'b000:         taken = eq;
         3'b001:         taken = !eq;
         3'b100, 3'b110: taken = lt;
         default:        taken = !lt;
      endcase
      e_alu = -1; e_imm = -1; e_asel = -1; e_bsel = (k == K_OP) ? 0 : 1;
      case (k)
         K_OP:     begin e_alu = alu_ref(f3, ins[30]); e_asel = 0; end
         K_OPIMM:  begin e_alu = alu_ref(f3, f3 == 3'b101 && ins[30]); e_imm = 0; e_asel = 0; end
         K_LUI:    begin e_alu = 10; e_imm = 3; e_asel = 0; end
         K_AUIPC:  begin e_alu = 0;  e_imm = 3; e_asel = 1; end
         K_JAL:    begin e_imm = 4;  e_asel = 1; end
         K_JALR:   begin e_imm = 0;  e_asel = 0; end
         K_LOAD:   begin e_alu = 0;  e_imm = 0; e_asel = 0; end
         K_STORE:  begin e_alu = 0;  e_imm = 1; e_asel = 0; end
         K_BRANCH: begin e_alu = 0;  e_imm = 2; e_asel = 1; end
         default:  e_bsel = -1;
      endcase
      total     = fw + 3 + (has_mem ? mw + 1 : 0) + (has_wb ? 1 : 0);
      mem_start = fw + 3;
      bus.BrEq  = eq;
      bus.BrLT  = lt;
      for (int c = 0; c < total; c++) begin
         in_fetch = (c <= fw);
         in_mem   = has_mem && c >= mem_start && c <= mem_start + mw;
         if (in_fetch) begin
            bus.memReady = (c == fw);
            bus.instr    = (c == fw) ? ins : $urandom;
         end else if (in_mem) begin
            bus.memReady = (c == mem_start + mw);
            bus.instr    = $urandom;
         end else begin
            bus.memReady = 1'($urandom_range(0, 1));
            bus.instr    = $urandom;
         end
         #1;
         last = (c == total - 1);
         chk("pcEn",   32'(bus.pcEn), 32'(last));
         chk("RegWEn", 32'(bus.RegWEn), 32'(last && writes));
         chk("ramEn",  32'(bus.ramEn), 32'(in_fetch || in_mem));
         chk("MemRW",  32'(bus.MemRW), 32'(in_mem && k == K_STORE));
         chk("halted", 32'(bus.halted), 0);
         chk("cycleCount", 32'(bus.cycleCount), (c > 15) ? 15 : c);
         if (c > fw) chk("irOut", bus.irOut, ins);
         if (last) chk("PCSel", 32'(bus.PCSel), 32'(jump || (k == K_BRANCH && taken)));
         if (last && has_wb) chk("WBSel", 32'(bus.WBSel), jump ? 2 : (k == K_LOAD) ? 1 : 0);
         if (c == fw + 2) begin
            if (e_alu >= 0)  chk("ALUop",  32'(bus.ALUop), e_alu);
            if (e_imm >= 0)  chk("ImmSel", 32'(bus.ImmSel), e_imm);
            if (e_asel >= 0) chk("ASel",   32'(bus.ASel), e_asel);
            if (e_bsel >= 0) chk("BSel",   32'(bus.BSel), e_bsel);
            if (k == K_BRANCH) chk("BrUn", 32'(bus.BrUn), 32'(f3[1]));
         end
         @(negedge clk);
      end
   endtask

   task automatic gen_rand(output logic [31:0] ins, output int k);
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] hi;
      logic [2:0]  bf3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      k   = $urandom_range(0, 9);
      f3  = 3'($urandom);
      rd  = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      hi  = $urandom;
      case (k)
         K_OP: begin
            f7  = ((f3 == 3'd0 || f3 == 3'd5) && hi[0]) ? 7'h20 : 7'h00;
            ins = {f7, rs2, rs1, f3, rd, 7'b0110011};
         end
         K_OPIMM: begin
            if (f3 == 3'd1)      f7 = 7'h00;
            else if (f3 == 3'd5) f7 = hi[0] ? 7'h20 : 7'h00;
            else                 f7 = hi[31:25];
            ins = {f7, rs2, rs1, f3, rd, 7'b0010011};
         end
         K_LUI:    ins = {hi[19:0], rd, 7'b0110111};
         K_AUIPC:  ins = {hi[19:0], rd, 7'b0010111};
         K_JAL:    ins = {hi[19:0], rd, 7'b1101111};
         K_JALR:   ins = {hi[11:0], rs1, 3'b000, rd, 7'b1100111};
         K_LOAD:   ins = {hi[11:0], rs1, 3'b010, rd, 7'b0000011};
         K_STORE:  ins = {hi[6:0], rs2, rs1, 3'b010, hi[11:7], 7'b0100011};
         K_BRANCH: ins = {hi[6:0], rs2, rs1, bf3[$urandom_range(0, 5)], hi[11:7], 7'b1100011};
         default:  ins = {hi[24:0], 7'b0001111};
      endcase
   endtask

   task automatic trap_test(input logic [31:0] ins, input string tag);
      bus.memReady = 1'b1;
      bus.instr    = ins;
      #1;
      chk({tag, ":fetch_ramEn"}, 32'(bus.ramEn), 1);
      @(negedge clk);
      bus.memReady = 1'b1;
      #1;
      chk({tag, ":dec_ramEn"},  32'(bus.ramEn), 0);
      chk({tag, ":dec_halted"}, 32'(bus.halted), 0);
      chk({tag, ":dec_irOut"},  bus.irOut, ins);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.memReady = 1'($urandom_range(0, 1));
         bus.instr    = $urandom;
         #1;
         chk({tag, ":halted"}, 32'(bus.halted), 1);
         chk({tag, ":pcEn"},   32'(bus.pcEn), 0);
         chk({tag, ":RegWEn"}, 32'(bus.RegWEn), 0);
         chk({tag, ":MemRW"},  32'(bus.MemRW), 0);
         chk({tag, ":ramEn"},  32'(bus.ramEn), 0);
         @(negedge clk);
      end
   endtask

   task automatic store_reset_test();
      bus.memReady = 1'b1;
      bus.instr    = 32'h0020A023;
      @(negedge clk);
      bus.memReady = 1'b0;
      @(negedge clk);
      #1;
      chk("sw_exec_ImmSel", 32'(bus.ImmSel), 1);
      chk("sw_exec_MemRW",  32'(bus.MemRW), 0);
      @(negedge clk);
      #1;
      chk("sw_mem_MemRW", 32'(bus.MemRW), 1);
      chk("sw_mem_ramEn", 32'(bus.ramEn), 1);
      #1;
      rst = 1'b1;
      #1;
      chk_all_zero("sw_rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("sw_after_cc",    32'(bus.cycleCount), 0);
      chk("sw_after_ramEn", 32'(bus.ramEn), 1);
      chk("sw_after_pcEn",  32'(bus.pcEn), 0);
      chk("sw_after_MemRW", 32'(bus.MemRW), 0);
   endtask

   initial begin
      logic [31:0] ins;
      int          k;
      rst          = 1'b1;
      bus.instr    = '0;
      bus.memReady = 1'b0;
      bus.BrEq     = 1'b0;
      bus.BrLT     = 1'b0;
      @(negedge clk);
      do_reset("reset");

      run_instr(32'h002081B3, K_OP,     0, 0, 1'b0, 1'b0);
      run_instr(32'h0000A183, K_LOAD,   0, 2, 1'b0, 1'b0);
      run_instr(32'h00208463, K_BRANCH, 0, 0, 1'b1, 1'b0);
      run_instr(32'h00208463, K_BRANCH, 0, 0, 1'b0, 1'b1);
      run_instr(32'h008000EF, K_JAL,    0, 0, 1'b0, 1'b0);
      run_instr(32'h0020A023, K_STORE,  1, 1, 1'b0, 1'b0);
      run_instr(32'h002081B3, K_OP,    18, 0, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         gen_rand(ins, k);
         run_instr(ins, k, $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      store_reset_test();
      run_instr(32'h002081B3, K_OP, 0, 0, 1'b0, 1'b0);

      trap_test(32'hFFFFFFFF, "illegal");
      do_reset("reset2");
      trap_test(32'h00000073, "ecall");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle control sequencer for the RV32I CPU datapath. It latches each fetched instruction and steps it through FETCH/DECODE/EXEC/MEM/WB. Each cycle it drives the datapath selects (PCSel, ImmSel, ASel, BSel, BrUn, WBSel, ALUop) and enables (pcEn, RegWEn, ramEn, MemRW). It sits between the instruction/data RAM and the register file/ALU, replacing hard-wired control in CPU.

Parameters:
CC_WIDTH, 4, width of cycleCount
TRAP_ON_ILLEGAL, 1, 1: illegal instruction enters TRAP; 0: illegal instruction retires as NOP

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
instr  in  32  RAM read data during FETCH
memReady  in  1  RAM handshake; access completes on the edge where it is 1
BrEq  in  1  branch comparator: rs1 == rs2
BrLT  in  1  branch comparator: rs1 < rs2 (signedness per BrUn)
irOut  out  32  latched instruction, to immediate generator and register addresses
pcEn  out  1  PC register load strobe
PCSel  out  1  0 = PC+4, 1 = ALU result
ImmSel  out  3  immediate format: I=0, S=1, B=2, U=3, J=4
RegWEn  out  1  register file write enable
ASel  out  1  ALU A operand: 0 = rs1, 1 = PC
BSel  out  1  ALU B operand: 0 = rs2, 1 = imm
BrUn  out  1  unsigned compare
WBSel  out  2  writeback source: 0 = ALU, 1 = RAM, 2 = PC+4
ALUop  out  4  ALU operation code
ramEn  out  1  RAM access enable
MemRW  out  1  0 = read, 1 = write
cycleCount  out  CC_WIDTH  cycles spent in the current instruction
halted  out  1  core stopped (TRAP or ECALL/EBREAK)

Behaviour:
- Reset: state=FETCH, irOut=0, cycleCount=0, halted=0. While rst=1, all outputs are forced to 0. A reset mid-instruction abandons the instruction; no pcEn or RegWEn pulse is issued.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: ramEn=1, MemRW=0, ASel=1. Hold while memReady=0. On the edge with memReady=1, irOut<=instr and go to DECODE.
- DECODE: one cycle. No enables. Go to EXEC, or to TRAP on an illegal or system opcode.
- EXEC, by opcode. Selects stay stable from DECODE through the end of the instruction.
  - OP: BSel=0; ALUop from funct3/funct7[5].
  - OP-IMM: BSel=1, ImmSel=I; funct7[5] is honoured only for funct3=101.
  - LUI: ALUop=PASSB, ImmSel=U.
  - AUIPC: ASel=1, ImmSel=U, ADD.
  - JAL: ASel=1, ImmSel=J.
  - JALR: ImmSel=I.
  - LOAD/STORE: ADD, ImmSel=I or S respectively.
  - BRANCH: ASel=1, ImmSel=B, ADD, BrUn=funct3[1]. The branch retires in EXEC: pcEn=1, PCSel=taken, then FETCH.
- Branch taken rule by funct3: 000 BrEq; 001 !BrEq; 100/110 BrLT; 101/111 !BrLT. funct3 010/011 is illegal.
- MEM: LOAD holds ramEn=1, MemRW=0 until memReady, then goes to WB. STORE holds ramEn=1, MemRW=1 until memReady; on that edge pcEn=1, PCSel=0, then FETCH.
- WB: one cycle. RegWEn=1 only if rd!=0. pcEn=1. PCSel=1 for JAL/JALR, else 0. WBSel=2 for JAL/JALR, 1 for LOAD, 0 otherwise. Then FETCH.
- Latency with memReady always 1: ALU/LUI/AUIPC/JAL/JALR = 4 cycles; LOAD = 5; STORE = 4; BRANCH = 3.
- cycleCount: cleared to 0 on the edge entering FETCH, else incremented each cycle. Saturates at all-ones; no wrap.
- Only LW/SW are legal (funct3=010). FENCE retires as a NOP: EXEC → pcEn, PCSel=0 → FETCH.
- ECALL/EBREAK: go to TRAP with halted=1.
- Illegal instruction: TRAP if TRAP_ON_ILLEGAL=1; otherwise NOP retire as for FENCE.
- TRAP: all enables 0, halted=1. Exits only via rst.
- A memReady pulse outside FETCH/MEM is ignored.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum;
  - opcode constants (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, FENCE 0001111, SYSTEM 1110011);
  - ALUop codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10;
  - ImmSel and WBSel encodings.
- One sub-module, cpu_instr_decode: purely combinational, irOut → selects, ALUop, legal flag, instruction class.
- The FSM, cycleCount and irOut register stay in cpu_control_fsm.

Test Plan:
- Reset, then release with memReady=1, instr=0x002081B3 (add x3,x1,x2). Required: states FETCH,DECODE,EXEC,WB; RegWEn=1 and pcEn=1 only in cycle 4; WBSel=0; ALUop=0; cycleCount 0,1,2,3.
- instr=0x0000A183 (lw x3,0(x1)), memReady held 0 for 2 MEM cycles. Required: MEM lasts 3 cycles with ramEn=1, MemRW=0; WB has WBSel=1 and RegWEn=1; total 7 cycles.
- instr=0x00208463 (beq x1,x2,+8) with BrEq=1, then the same with BrEq=0. Required: pcEn in EXEC with PCSel=1, then PCSel=0; RegWEn is never 1; 3 cycles each.
- instr=0x008000EF (jal x1,+8). Required in WB: RegWEn=1, WBSel=2, PCSel=1, pcEn=1; ImmSel=4 and ASel=1 in EXEC.
- instr=0xFFFFFFFF. Required: DECODE → TRAP; halted=1; no pcEn, RegWEn or MemRW thereafter, even with memReady toggling.
- Store 0x0020A023 (sw x2,0(x1)): assert rst during MEM with MemRW=1. Required: all outputs 0 immediately; after release, FETCH with cycleCount=0 and no pcEn.
